// File: rtl/reset_seq_gen.sv
// rtl/reset_seq_gen.sv - multi-channel RTC-timed reset/enable power-up sequencer
//
// Releases NUM_CH subsystem resets one at a time in index order. Channel k
// waits rst_dly[k] RTC ticks before its reset is released, then en_dly[k]
// ticks before its enable is qualified. Both delay sets are latched at the
// start of every sequence, so later input changes do not disturb a run.
//
// Ports:
//   clk_i       sequencer clock (rising edge)
//   arst_ni     asynchronous active-low reset
//   rtc_i       RTC square wave, asynchronous; each rising edge is one tick
//   restart_i   single-cycle pulse that restarts the whole sequence
//   en_i        per-channel enable request
//   rst_dly_i   per-channel pre-release delay, channel k at [k*CNT_W +: CNT_W]
//   en_dly_i    per-channel post-release enable delay, same packing
//   rst_no      per-channel reset, 0 = held in reset, 1 = released
//   en_o        registered en_i gated by the per-channel enable qualification
//   busy_o      sequence in progress
//   done_o      all channels released and enable-qualified
//   ch_o        index of the channel currently being sequenced
//   wdog_err_o  sticky RTC-stall error (only with RESET_SEQ_WDOG_EN)
//
// Build option: define RESET_SEQ_WDOG_EN to add the RTC-stall watchdog.

module reset_seq_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                                         clk_i,
  input  logic                                         arst_ni,
  input  logic                                         rtc_i,
  input  logic                                         restart_i,
  input  logic [NUM_CH-1:0]                            en_i,
  input  logic [NUM_CH*CNT_W-1:0]                      rst_dly_i,
  input  logic [NUM_CH*CNT_W-1:0]                      en_dly_i,
  output logic [NUM_CH-1:0]                            rst_no,
  output logic [NUM_CH-1:0]                            en_o,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] ch_o
`ifdef RESET_SEQ_WDOG_EN
  ,
  output logic                                         wdog_err_o
`endif
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RST_WAIT,
    S_EN_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              rtc_sync_q;
  logic                    tick;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [NUM_CH*CNT_W-1:0] rst_dly_q, rst_dly_d;
  logic [NUM_CH*CNT_W-1:0] en_dly_q, en_dly_d;
  logic [NUM_CH-1:0]       rst_n_q, rst_n_d;
  logic [NUM_CH-1:0]       en_ok_q, en_ok_d;
  logic [NUM_CH-1:0]       en_q;
  logic [CNT_W-1:0]        cur_rst_dly, cur_en_dly;
  logic                    busy;
  logic                    restart_ok;

  // Bits [1:0] form the 2-FF synchronizer; bit 2 holds the previous
  // synchronized level for rising-edge detection.
  assign tick = rtc_sync_q[1] & ~rtc_sync_q[2];

  assign busy = (state_q == S_LOAD) || (state_q == S_RST_WAIT) || (state_q == S_EN_WAIT);

  // A restart arriving before the sequence has left S_LOAD changes nothing.
  assign restart_ok = restart_i && (state_q != S_IDLE) && (state_q != S_LOAD);

  assign cur_rst_dly = rst_dly_q[int'(ch_q)*CNT_W +: CNT_W];
  assign cur_en_dly  = en_dly_q[int'(ch_q)*CNT_W +: CNT_W];

`ifdef RESET_SEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_err_q;
  logic              wdog_hit;

  assign wdog_hit = busy && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES));

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else if (restart_ok) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else if (wdog_hit) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b1;
    end else if (!busy || tick) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end
  end

  assign wdog_err_o = wdog_err_q;
  assign done_o     = (state_q == S_DONE) && !wdog_err_q;
`else
  assign done_o     = (state_q == S_DONE);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    rst_n_d   = rst_n_q;
    en_ok_d   = en_ok_q;
    rst_dly_d = rst_dly_q;
    en_dly_d  = en_dly_q;

    unique case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        rst_dly_d = rst_dly_i;
        en_dly_d  = en_dly_i;
        cnt_d     = '0;
        ch_d      = '0;
        state_d   = S_RST_WAIT;
      end
      S_RST_WAIT: begin
        // Compare before counting: a zero delay finishes in one cycle, the
        // counter never exceeds the target, and a tick landing on the
        // completing cycle is dropped rather than carried into the next stage.
        if (cnt_q == cur_rst_dly) begin
          rst_n_d[ch_q] = 1'b1;
          cnt_d         = '0;
          state_d       = S_EN_WAIT;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EN_WAIT: begin
        if (cnt_q == cur_en_dly) begin
          en_ok_d[ch_q] = 1'b1;
          cnt_d         = '0;
          if (ch_q == LAST_CH) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_RST_WAIT;
          end
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Restart overrides whatever the current stage decided this cycle.
    if (restart_ok) begin
      rst_n_d = '0;
      en_ok_d = '0;
      cnt_d   = '0;
      ch_d    = '0;
      state_d = S_LOAD;
    end
`ifdef RESET_SEQ_WDOG_EN
    else if (wdog_hit) begin
      state_d = S_DONE;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rtc_sync_q <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      rst_dly_q  <= '0;
      en_dly_q   <= '0;
      rst_n_q    <= '0;
      en_ok_q    <= '0;
      en_q       <= '0;
    end else begin
      rtc_sync_q <= {rtc_sync_q[1:0], rtc_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      rst_dly_q  <= rst_dly_d;
      en_dly_q   <= en_dly_d;
      rst_n_q    <= rst_n_d;
      en_ok_q    <= en_ok_d;
      en_q       <= en_i & en_ok_q;
    end
  end

  assign rst_no = rst_n_q;
  assign en_o   = en_q;
  assign busy_o = busy;
  assign ch_o   = ch_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// tb/tb_reset_seq_gen.sv - self-checking bench for reset_seq_gen

module tb_reset_seq_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int MAXE   = 8192;
  localparam int BIG    = 1 << 30;

  logic                    clk;
  logic                    arst_ni;
  logic                    rtc_i;
  logic                    restart_i;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH*CNT_W-1:0] rst_dly_i;
  logic [NUM_CH*CNT_W-1:0] en_dly_i;
  logic [NUM_CH-1:0]       rst_no;
  logic [NUM_CH-1:0]       en_o;
  logic                    busy_o;
  logic                    done_o;
  logic [1:0]              ch_o;

  reset_seq_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (1024)
  ) dut (
    .clk_i     (clk),
    .arst_ni   (arst_ni),
    .rtc_i     (rtc_i),
    .restart_i (restart_i),
    .en_i      (en_i),
    .rst_dly_i (rst_dly_i),
    .en_dly_i  (en_dly_i),
    .rst_no    (rst_no),
    .en_o      (en_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ch_o      (ch_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int                n_cmp;
  int                n_err;
  int                g;          // rising edges counted since the first reset
  bit                r [MAXE];   // rtc_i level presented at edge e
  bit                in_rst;
  int                ep_a;       // edge at which the current sequence entered LOAD
  int                rel_e [NUM_CH];
  int                en_e  [NUM_CH];
  logic [NUM_CH-1:0] prev_enok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, g);
    end
  endtask

  function automatic bit rv(int e);
    return (e >= 0 && e < MAXE) ? r[e] : 1'b0;
  endfunction

  // Rising rtc_i level first seen at edge e-2 is acted on at edge e.
  function automatic bit tick_at(int e);
    return rv(e - 2) && !rv(e - 3);
  endfunction

  function automatic int ticks_between(int lo, int hi);
    int c = 0;
    for (int e = lo + 1; e < hi; e++) if (tick_at(e)) c++;
    return c;
  endfunction

  // Edge at which a stage entered at edge s with delay d completes.
  function automatic int stage_end(int s, int d);
    int c = 0;
    if (d == 0) return s + 1;
    for (int e = s + 1; e < MAXE; e++) begin
      if (tick_at(e)) begin
        c++;
        if (c == d) return e + 1;
      end
    end
    return BIG;
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < NUM_CH; k++) begin
      rel_e[k] = BIG;
      en_e[k]  = BIG;
    end
  endtask

  task automatic model_and_check();
    logic [NUM_CH-1:0] exp_rst, exp_enok, exp_en;
    int s, nch;
    if (restart_i && g > ep_a + 1) begin
      ep_a = g;
      clear_sched();
    end
    if (g == ep_a + 1) begin
      s = g;
      for (int k = 0; k < NUM_CH; k++) begin
        rel_e[k] = stage_end(s, int'(rst_dly_i[k*CNT_W +: CNT_W]));
        s        = rel_e[k];
        en_e[k]  = stage_end(s, int'(en_dly_i[k*CNT_W +: CNT_W]));
        s        = en_e[k];
      end
    end
    nch = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_rst[k]  = (g >= rel_e[k]);
      exp_enok[k] = (g >= en_e[k]);
      if (g >= en_e[k]) nch++;
    end
    if (nch > NUM_CH - 1) nch = NUM_CH - 1;
    exp_en    = en_i & prev_enok;
    prev_enok = exp_enok;
    check_eq("rst_no", rst_no, exp_rst);
    check_eq("en_o", en_o, exp_en);
    check_eq("busy_o", busy_o, (g >= ep_a) && (g < en_e[NUM_CH-1]));
    check_eq("done_o", done_o, g >= en_e[NUM_CH-1]);
    check_eq("ch_o", ch_o, nch);
  endtask

  task automatic cycle();
    rtc_i = rv(g + 1);
    @(posedge clk);
    g++;
    @(negedge clk);
    if (!in_rst) model_and_check();
  endtask

  task automatic do_reset();
    #2;
    arst_ni   = 1'b0;
    restart_i = 1'b0;
    rtc_i     = 1'b0;
    #1;
    check_eq("arst_rst_no", rst_no, 0);
    check_eq("arst_en_o", en_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_done", done_o, 0);
    check_eq("arst_ch", ch_o, 0);
    for (int e = g + 1; e <= g + 3; e++) r[e] = 1'b0;
    in_rst = 1'b1;
    repeat (3) cycle();
    arst_ni   = 1'b1;
    in_rst    = 1'b0;
    ep_a      = g + 1;
    prev_enok = '0;
    clear_sched();
  endtask

  // mode 0: static low, 1: period 8 (4 low / 4 high), 2: random runs
  task automatic fill_rtc(input int mode);
    int e;
    bit lvl;
    int len;
    e   = g + 1;
    lvl = 1'b0;
    while (e < MAXE) begin
      if (mode == 0) begin
        r[e] = 1'b0;
        e++;
      end else if (mode == 1) begin
        r[e] = (((e - g - 1) % 8) >= 4);
        e++;
      end else begin
        len = $urandom_range(1, 5);
        for (int i = 0; i < len && e < MAXE; i++) begin
          r[e] = lvl;
          e++;
        end
        lvl = !lvl;
      end
    end
  endtask

  task automatic setup_a();
    rst_dly_i = {NUM_CH{8'd2}};
    en_dly_i  = {NUM_CH{8'd1}};
    en_i      = '1;
    fill_rtc(1);
  endtask

  task automatic rand_dly();
    for (int k = 0; k < NUM_CH; k++) begin
      rst_dly_i[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
      en_dly_i[k*CNT_W +: CNT_W]  = CNT_W'($urandom_range(0, 3));
    end
  endtask

  initial begin
    int seen;
    int i;
    n_cmp     = 0;
    n_err     = 0;
    g         = 0;
    in_rst    = 1'b0;
    arst_ni   = 1'b1;
    rtc_i     = 1'b0;
    restart_i = 1'b0;
    en_i      = '0;
    rst_dly_i = '0;
    en_dly_i  = '0;
    ep_a      = 0;
    prev_enok = '0;
    clear_sched();
    @(negedge clk);

    // Nominal sequence: releases at ticks 2,5,8,11, done after tick 12.
    do_reset();
    setup_a();
    seen = 0;
    for (i = 0; i < 400 && !done_o; i++) begin
      cycle();
      if ($countones(rst_no) > seen) begin
        seen = $countones(rst_no);
        check_eq("A_rel_tick", ticks_between(ep_a + 1, g), 3 * seen - 1);
      end
    end
    check_eq("A_done", done_o, 1);
    check_eq("A_done_tick", ticks_between(ep_a + 1, g), 12);
    repeat (5) cycle();

    // Restart during EN_WAIT of channel 2 with new delays.
    do_reset();
    setup_a();
    for (i = 0; i < 400 && !(ch_o == 2'd2 && rst_no == 4'b0111); i++) cycle();
    check_eq("C_reach_ch2", (ch_o == 2'd2 && rst_no == 4'b0111), 1);
    rst_dly_i = {NUM_CH{8'd3}};
    restart_i = 1'b1;
    cycle();
    restart_i = 1'b0;
    check_eq("C_rst_cleared", rst_no, 0);
    check_eq("C_busy", busy_o, 1);
    for (i = 0; i < 400 && !rst_no[0]; i++) cycle();
    check_eq("C_rel_seen", rst_no[0], 1);
    check_eq("C_first_rel_tick", ticks_between(ep_a + 1, g), 3);
    repeat (20) cycle();

    // Restart coinciding with the final enable completion.
    do_reset();
    setup_a();
    cycle();
    cycle();
    for (i = 0; i < 400 && g + 1 < en_e[NUM_CH-1]; i++) cycle();
    restart_i = 1'b1;
    cycle();
    restart_i = 1'b0;
    check_eq("D_done_low", done_o, 0);
    check_eq("D_busy_load", busy_o, 1);
    check_eq("D_rst_no", rst_no, 0);
    repeat (30) cycle();

    // Asynchronous reset mid-sequence, then the sequence restarts at channel 0.
    do_reset();
    setup_a();
    for (i = 0; i < 400 && rst_no != 4'b0011; i++) cycle();
    check_eq("E_reach_0011", rst_no, 4'b0011);
    do_reset();
    for (i = 0; i < 400 && !rst_no[0]; i++) cycle();
    check_eq("E_restart_ch0", rst_no, 4'b0001);
    repeat (10) cycle();

    // All delays zero, RTC static.
    do_reset();
    rst_dly_i = '0;
    en_dly_i  = '0;
    en_i      = '1;
    fill_rtc(0);
    for (i = 0; i < 40 && !done_o; i++) cycle();
    check_eq("B_done", done_o, 1);
    check_eq("B_cycles", g - ep_a + 1, 2 + 2 * NUM_CH);
    check_eq("B_busy_low", busy_o, 0);
    repeat (3) cycle();

    // Randomized runs.
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      rand_dly();
      fill_rtc(2);
      for (int c = 0; c < 500; c++) begin
        en_i      = NUM_CH'($urandom());
        restart_i = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 29) == 0) rand_dly();
        if (rnd == 1 && c == 250) begin
          do_reset();
          en_i = NUM_CH'($urandom());
        end
        cycle();
      end
      restart_i = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
